// File: rtl/coeff_distribute.sv
// ---------------------------------------------------------------------------
// coeff_distribute
//   Parallel-to-serial coefficient streamer. It accepts one frame of NCOEF
//   coefficients over a valid/ready handshake and then emits them one per
//   beat on a valid/ready stream, index 0 first. The final beat of a frame
//   is flagged with o_last.
//
//   Optional feature (macro COEFF_DISTRIBUTE_CHECKSUM_EN):
//     After coefficient NCOEF-1, one extra beat is sent. It carries the
//     modulo-2^CW sum of all coefficients, uses index 0, and is the only
//     beat of the frame with o_last set.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous, active-low reset
//   i_valid   in   parallel frame valid
//   i_ready   out  frame can be accepted (decoded from state only)
//   i_coeffs  in   frame; coefficient k at bits [k*CW +: CW]
//   o_valid   out  output beat valid (registered)
//   o_ready   in   downstream accepts the current beat
//   o_coeff   out  current coefficient (registered)
//   o_idx     out  index of the current coefficient (registered)
//   o_last    out  final beat of the frame (registered)
// ---------------------------------------------------------------------------
module coeff_distribute #(
  parameter  int unsigned CW    = 8,
  parameter  int unsigned NCOEF = 8,
  localparam int unsigned IW    = $clog2(NCOEF)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  output logic                  i_ready,
  input  logic [NCOEF*CW-1:0]   i_coeffs,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic [CW-1:0]         o_coeff,
  output logic [IW-1:0]         o_idx,
  output logic                  o_last
);

  localparam logic S_IDLE = 1'b0;
  localparam logic S_SEND = 1'b1;

  localparam logic [IW-1:0] LAST_IDX = IW'(NCOEF - 1);

  logic                r_state;
  logic [NCOEF*CW-1:0] r_frame;
  logic                r_valid;
  logic [CW-1:0]       r_coeff;
  logic [IW-1:0]       r_idx;
  logic                r_last;

  logic [CW-1:0]       w_coef [NCOEF];
  logic [IW-1:0]       w_idx_nxt;
  logic                w_beat;

`ifdef COEFF_DISTRIBUTE_CHECKSUM_EN
  logic [CW-1:0]       r_sum;
  logic [CW-1:0]       w_sum;

  // Checksum is taken from the incoming word at latch time, so it is
  // already stable long before its beat comes up.
  always_comb begin
    w_sum = '0;
    for (int unsigned k = 0; k < NCOEF; k++) begin
      w_sum = w_sum + i_coeffs[k*CW +: CW];
    end
  end
`endif

  always_comb begin
    for (int unsigned k = 0; k < NCOEF; k++) begin
      w_coef[k] = r_frame[k*CW +: CW];
    end
  end

  assign w_idx_nxt = r_idx + IW'(1);
  assign w_beat    = r_valid && o_ready;

  assign i_ready = (r_state == S_IDLE);
  assign o_valid = r_valid;
  assign o_coeff = r_coeff;
  assign o_idx   = r_idx;
  assign o_last  = r_last;

  // Output registers are loaded one beat ahead. The next coefficient is
  // fetched from the frame register as the current beat transfers, which
  // keeps every output registered while sustaining one beat per cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_frame <= '0;
      r_valid <= 1'b0;
      r_coeff <= '0;
      r_idx   <= '0;
      r_last  <= 1'b0;
`ifdef COEFF_DISTRIBUTE_CHECKSUM_EN
      r_sum   <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_valid) begin
            r_frame <= i_coeffs;
            r_state <= S_SEND;
            r_valid <= 1'b1;
            r_coeff <= i_coeffs[CW-1:0];
            r_idx   <= '0;
            r_last  <= 1'b0;
`ifdef COEFF_DISTRIBUTE_CHECKSUM_EN
            r_sum   <= w_sum;
`endif
          end
        end
        S_SEND: begin
          if (w_beat) begin
            if (r_last) begin
              r_state <= S_IDLE;
              r_valid <= 1'b0;
              r_coeff <= '0;
              r_idx   <= '0;
              r_last  <= 1'b0;
`ifdef COEFF_DISTRIBUTE_CHECKSUM_EN
            end else if (r_idx == LAST_IDX) begin
              r_coeff <= r_sum;
              r_idx   <= '0;
              r_last  <= 1'b1;
            end else begin
              r_coeff <= w_coef[w_idx_nxt];
              r_idx   <= w_idx_nxt;
              r_last  <= 1'b0;
            end
`else
            end else begin
              r_coeff <= w_coef[w_idx_nxt];
              r_idx   <= w_idx_nxt;
              r_last  <= (w_idx_nxt == LAST_IDX);
            end
`endif
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/coeff_distribute.md
Name: coeff_distribute

Overview:
- Transmit-side counterpart of the coefficient collector: a parallel-to-serial coefficient streamer.
- Accepts one full frame of NCOEF coefficients as a parallel word over a valid/ready handshake.
- Emits the coefficients one per beat on a valid/ready output stream, index 0 first, flagging the final beat.
- Sits between the coefficient store/controller and the serial coefficient link feeding the collector.

Parameters:
- CW, 8, coefficient width in bits
- NCOEF, 8, coefficients per frame (>=2)
- IW, $clog2(NCOEF), index width (derived, not overridden)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- i_valid  in  1  parallel frame valid
- i_ready  out  1  block can accept a frame
- i_coeffs  in  NCOEF*CW  frame; coefficient k at bits [k*CW +: CW]
- o_valid  out  1  output beat valid
- o_ready  in  1  downstream accepts beat
- o_coeff  out  CW  current coefficient
- o_idx  out  IW  index of current coefficient
- o_last  out  1  high on final beat of frame

Behaviour:
- Reset (rst=0, async, immediate):
  - state=IDLE; o_valid=0, o_coeff=0, o_idx=0, o_last=0.
  - Internal frame register cleared.
  - i_ready is combinational from state and is therefore 1 while in reset.
- States: IDLE, SEND.
- IDLE:
  - i_ready=1, o_valid=0.
  - On i_valid&&i_ready at an edge: latch i_coeffs into the frame register, idx=0, go to SEND.
  - o_valid rises the cycle after acceptance, giving 1-cycle latency from frame accept to first beat.
- SEND:
  - i_ready=0; i_valid is ignored and the frame is not consumed.
  - o_valid=1; o_coeff=frame[idx]; o_idx=idx; o_last=(idx==NCOEF-1).
  - Beat transfers on an edge with o_valid&&o_ready. Non-last beat: idx+1.
  - Last beat transfers: return to IDLE, o_valid=0, idx=0.
- Stall rule: while o_valid&&!o_ready, o_coeff/o_idx/o_last are held stable; no beat is lost or duplicated.
- Throughput:
  - 1 beat/cycle when o_ready is held high.
  - NCOEF+1 cycles minimum per frame, because of the mandatory IDLE cycle between frames.
- All outputs are registered except i_ready (decoded from the state register only; no combinational path from o_ready or i_valid).
- Frame register is written only on acceptance, so later changes on i_coeffs never affect a frame in flight.
- Reset mid-frame: the in-flight frame is discarded. After release, the block is in IDLE and the next frame starts at idx 0.
- o_ready asserted while o_valid=0 has no effect.

Optional Feature:
- Macro: COEFF_DISTRIBUTE_CHECKSUM_EN.
- Defined:
  - After coefficient NCOEF-1, one extra beat is sent: o_coeff = sum of all NCOEF coefficients modulo 2^CW (unsigned wraparound), o_idx=0.
  - o_last is asserted only on this checksum beat, not on coefficient NCOEF-1.
  - Frame length is NCOEF+1 beats.
  - The checksum is computed incrementally during SEND or at latch time, and is stable on its beat.
  - The same stall rules apply to the checksum beat.
- Undefined: no checksum logic or beat; behaviour is exactly as described in Behaviour.

Test Plan:
- Reset: rst=0 at t=0, released after 10 cycles -> o_valid=0, o_coeff=0, o_idx=0, o_last=0, i_ready=1 throughout reset and the first cycle after release.
- Basic frame (CW=8, NCOEF=8), o_ready=1, i_coeffs = 0x01..0x08 (k=0 -> 0x01):
  - Beats 0x01..0x08 on consecutive cycles with o_idx 0..7.
  - o_last only with 0x08; first o_valid one cycle after accept; i_ready=0 during SEND, 1 again the cycle after the last beat.
- Backpressure: same frame with o_ready toggled 1,0,0,1,0,1,... -> the exact sequence 0x01..0x08 is received once each, and outputs are held constant on every stalled cycle.
- Input isolation: frame 0x10..0x17 accepted, then i_coeffs changed to 0xFF.. with i_valid=1 during SEND -> output remains 0x10..0x17. Next frame is accepted only once back in IDLE, and carries the then-current i_coeffs.
- Async reset mid-frame: assert rst=0 between clock edges after beat idx=3 -> o_valid drops immediately without waiting for a clock edge. After release, a new frame 0xA0..0xA7 streams from idx 0.
- With COEFF_DISTRIBUTE_CHECKSUM_EN, frame 0x01..0x08 -> 9 beats, 9th o_coeff=0x24 with o_last=1. Frame of eight 0x40 -> checksum 0x00 (wrap).
